// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Decode and the hazard unit import the same package so that the bubble
// instruction, reset PC and PC width stay consistent across the pipeline.
package if_stage_pkg;

   // Word-PC width; the PC wraps modulo 2**PC_W.
   localparam int PC_W   = 9;
   // Instruction width.
   localparam int INST_W = 32;

   // First fetch address after reset.
   localparam logic [PC_W-1:0]   RESET_PC = 9'd0;
   // Instruction shown to decode whenever the slot is a bubble (addi x0,x0,0).
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   // Fetch-stage state.
   //   BOOT   : first cycle after reset, nothing valid has returned yet
   //   RUN    : the returning word belongs to the correct path
   //   BUBBLE : the returning word was fetched before a redirect and is killed
   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2
   } if_state_e;

   // Sequential next word address; wraps from the top word back to zero.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + 9'd1;
   endfunction

   // A slot is only a real instruction while the stage is in RUN.
   function automatic logic state_is_bubble(input if_state_e st);
      return (st != ST_RUN);
   endfunction

endpackage : if_stage_pkg

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's bus signals: the instruction-memory port,
// the redirect/stall inputs from decode and the hazard unit, and the
// decode slot presented to decode.
interface if_stage_if;
   import if_stage_pkg::*;

   // Instruction memory port (synchronous read, 1-cycle latency).
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_data;

   // Control from decode / hazard unit.
   logic              stall;
   logic              jump_valid;
   logic [PC_W-1:0]   jump_addr;

   // Decode slot.
   logic [PC_W-1:0]   pc_out;
   logic [INST_W-1:0] inst_out;
   logic              wist;

   // View of the fetch stage itself.
   modport master (
      input  stall,
      input  jump_valid,
      input  jump_addr,
      input  imem_data,
      output imem_addr,
      output pc_out,
      output inst_out,
      output wist
   );

   // View of the surrounding pipeline / memory.
   modport slave (
      output stall,
      output jump_valid,
      output jump_addr,
      output imem_data,
      input  imem_addr,
      input  pc_out,
      input  inst_out,
      input  wist
   );

endinterface : if_stage_if

// File: rtl/if_hold_buf.sv
// Stall capture buffer and decode-slot instruction mux.
// On the first stalled edge the word currently returning from memory is
// latched so the decode slot stays stable however long the stall lasts;
// memory keeps being addressed at the held fetch PC, so once the stall
// drops the live memory data is correct again and the buffer is released.
module if_hold_buf
   import if_stage_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stall,
   input  logic              i_wist,
   input  logic [INST_W-1:0] i_imem_data,
   output logic [INST_W-1:0] o_inst
);

   logic [INST_W-1:0] r_hold_inst;
   logic              r_hold_vld;
   logic [INST_W-1:0] w_inst;

   // Capture the returning word on the first stalled edge; release on the first unstalled edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_inst <= NOP_INST;
         r_hold_vld  <= 1'b0;
      end else if (i_stall) begin
         if (!r_hold_vld) begin
            r_hold_inst <= i_imem_data;
            r_hold_vld  <= 1'b1;
         end else begin
            r_hold_inst <= r_hold_inst;
            r_hold_vld  <= 1'b1;
         end
      end else begin
         r_hold_inst <= r_hold_inst;
         r_hold_vld  <= 1'b0;
      end
   end

   // Select what decode sees: bubble NOP, captured word, or live memory data.
   always_comb begin
      w_inst = NOP_INST;
      if (i_wist) begin
         w_inst = NOP_INST;
      end else if (r_hold_vld) begin
         w_inst = r_hold_inst;
      end else begin
         w_inst = i_imem_data;
      end
   end

   assign o_inst = w_inst;

endmodule : if_hold_buf

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the fetch PC (pc_f, drives memory) and the PC of the word returning
// this cycle (pc_d). A taken redirect kills the one word already in flight,
// so every redirect costs exactly one bubble. A stall freezes the PCs, the
// state and (through if_hold_buf) the decode slot; a stall also overrides a
// concurrent redirect, which decode re-issues once the stall drops.
module if_stage
   import if_stage_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   if_stage_if.master  if_bus
);

   logic [PC_W-1:0]   r_pc_f;
   logic [PC_W-1:0]   r_pc_d;
   if_state_e         r_state;

   logic [PC_W-1:0]   w_pc_f_nxt;
   logic [PC_W-1:0]   w_pc_d_nxt;
   if_state_e         w_state_nxt;
   logic              w_wist;
   logic [INST_W-1:0] w_inst;

   // Next PC / next state: stall holds everything, otherwise redirect or sequential fetch.
   always_comb begin
      w_pc_f_nxt  = r_pc_f;
      w_pc_d_nxt  = r_pc_d;
      w_state_nxt = r_state;
      if (if_bus.stall) begin
         w_pc_f_nxt = r_pc_f;
         w_pc_d_nxt = r_pc_d;
         case (r_state)
            ST_BOOT:   w_state_nxt = ST_BOOT;
            ST_RUN:    w_state_nxt = ST_RUN;
            ST_BUBBLE: w_state_nxt = ST_BUBBLE;
            default:   w_state_nxt = ST_BOOT;
         endcase
      end else if (if_bus.jump_valid) begin
         // The word for the old pc_f is already in flight; mark it killed.
         w_pc_f_nxt  = if_bus.jump_addr;
         w_pc_d_nxt  = r_pc_f;
         w_state_nxt = ST_BUBBLE;
      end else begin
         w_pc_f_nxt  = pc_inc(r_pc_f);
         w_pc_d_nxt  = r_pc_f;
         w_state_nxt = ST_RUN;
      end
   end

   // PC and state registers; reset discards every in-flight fetch.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc_f  <= RESET_PC;
         r_pc_d  <= RESET_PC;
         r_state <= ST_BOOT;
      end else begin
         r_pc_f  <= w_pc_f_nxt;
         r_pc_d  <= w_pc_d_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign w_wist = state_is_bubble(r_state);

   if_hold_buf u_hold_buf (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_stall     (if_bus.stall),
      .i_wist      (w_wist),
      .i_imem_data (if_bus.imem_data),
      .o_inst      (w_inst)
   );

   assign if_bus.imem_addr = r_pc_f;
   assign if_bus.pc_out    = r_pc_d;
   assign if_bus.wist      = w_wist;
   assign if_bus.inst_out  = w_inst;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed per-cycle vectors with hand-computed
// expected decode-slot values, checked by a separate monitor via a queue.
// Instruction memory model: imem[k] = k + 0x100, 1-cycle read latency.
module tb_if_stage;
   import if_stage_pkg::*;

   typedef struct packed {
      logic        wist;
      logic [8:0]  pc;
      logic [31:0] inst;
      logic [8:0]  addr;
      logic [7:0]  cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   n_err;
   int   n_chk;
   int   cyc_n;
   exp_t exp_q[$];

   if_stage_if bus ();

   if_stage dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .if_bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memory model.
   always @(posedge clk) begin
      bus.imem_data <= {23'd0, bus.imem_addr} + 32'h0000_0100;
   end

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
      n_chk = n_chk + 1;
      if (act !== expv) begin
         n_err = n_err + 1;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
      end
   endtask

   // Monitor: pop the expectation for this cycle and compare the decode slot.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("wist",      int'(e.cyc), {31'd0, bus.wist},      {31'd0, e.wist});
         chk("pc_out",    int'(e.cyc), {23'd0, bus.pc_out},    {23'd0, e.pc});
         chk("inst_out",  int'(e.cyc), bus.inst_out,           e.inst);
         chk("imem_addr", int'(e.cyc), {23'd0, bus.imem_addr}, {23'd0, e.addr});
      end
   end

   // One cycle: drive inputs (sampled at the coming edge) and queue the slot expected now.
   task automatic step(input logic r, input logic s, input logic jv, input logic [8:0] ja,
                       input logic ew, input logic [8:0] epc, input logic [31:0] ei,
                       input logic [8:0] ea);
      exp_t e;
      rst            = r;
      bus.stall      = s;
      bus.jump_valid = jv;
      bus.jump_addr  = ja;
      e.wist = ew;
      e.pc   = epc;
      e.inst = ei;
      e.addr = ea;
      e.cyc  = cyc_n[7:0];
      exp_q.push_back(e);
      cyc_n = cyc_n + 1;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      n_err = 0;
      n_chk = 0;
      cyc_n = 0;
      rst            = 1'b1;
      bus.stall      = 1'b0;
      bus.jump_valid = 1'b0;
      bus.jump_addr  = 9'd0;
      repeat (2) @(posedge clk);
      #1;
      //    rst   stall jv    ja       wist  pc       inst          addr
      // Reset state, then free run.
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd0,   NOP,          9'd0);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd0,   32'h100,      9'd1);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd1,   32'h101,      9'd2);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd2,   32'h102,      9'd3);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd3,   32'h103,      9'd4);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd4,   32'h104,      9'd5);
      // Redirect to 40 while pc_out=5.
      step(1'b0, 1'b0, 1'b1, 9'd40,  1'b0, 9'd5,   32'h105,      9'd6);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd6,   NOP,          9'd40);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd40,  32'h128,      9'd41);
      // Redirect back to 6 to reach pc_out=7.
      step(1'b0, 1'b0, 1'b1, 9'd6,   1'b0, 9'd41,  32'h129,      9'd42);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd42,  NOP,          9'd6);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd6,   32'h106,      9'd7);
      // Three-cycle stall at pc_out=7.
      step(1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 9'd7,   32'h107,      9'd8);
      step(1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 9'd7,   32'h107,      9'd8);
      step(1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 9'd7,   32'h107,      9'd8);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd7,   32'h107,      9'd8);
      // Stall with jump for two cycles, then jump alone.
      step(1'b0, 1'b1, 1'b1, 9'd100, 1'b0, 9'd8,   32'h108,      9'd9);
      step(1'b0, 1'b1, 1'b1, 9'd100, 1'b0, 9'd8,   32'h108,      9'd9);
      step(1'b0, 1'b0, 1'b1, 9'd100, 1'b0, 9'd8,   32'h108,      9'd9);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd9,   NOP,          9'd100);
      // Jump to 510 and wrap past 511.
      step(1'b0, 1'b0, 1'b1, 9'd510, 1'b0, 9'd100, 32'h164,      9'd101);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd101, NOP,          9'd510);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd510, 32'h2FE,      9'd511);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd511, 32'h2FF,      9'd0);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd0,   32'h100,      9'd1);
      // Reset asserted in the second stalled cycle (hold buffer valid).
      step(1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 9'd1,   32'h101,      9'd2);
      step(1'b1, 1'b1, 1'b0, 9'd0,   1'b0, 9'd1,   32'h101,      9'd2);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd0,   NOP,          9'd0);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd0,   32'h100,      9'd1);
      // Self-redirect to the current fetch PC still inserts a bubble.
      step(1'b0, 1'b0, 1'b1, 9'd2,   1'b0, 9'd1,   32'h101,      9'd2);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd2,   NOP,          9'd2);
      step(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd2,   32'h102,      9'd3);
      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      #1;
      n_chk = n_chk + 1;
      if (exp_q.size() != 0) begin
         n_err = n_err + 1;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_if_stage
